// File: rtl/coremem_ws.sv
// coremem_ws: bridges the core LSU data port (req/gnt/rvalid) to a single-port
// synchronous SRAM with a fixed, parametrised read latency. Out-of-range
// accesses are granted, never reach the SRAM, and answer with an error.
module coremem_ws #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    input  logic                         data_we_i,
    input  logic [DATA_WIDTH/8-1:0]      data_be_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic [DATA_WIDTH-1:0]        data_wdata_i,
    output logic [DATA_WIDTH-1:0]        data_rdata_o,
    output logic                         data_err_o,
    output logic                         mem_ce_o,
    output logic                         mem_we_o,
    output logic [DATA_WIDTH/8-1:0]      mem_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam int unsigned OffW = $clog2(BeW);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    // Spare encodings (2'b00, 2'b11) are illegal and recover to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b01,
        StWait = 2'b10
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              pend_we_q;
    logic              pend_err_q;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  last_cycle;

    // Address decode, grant and SRAM drive; all combinational from the core side.
    always_comb begin
        word_idx   = data_addr_i >> OffW;
        in_range   = (word_idx < ADDR_WIDTH'(MEM_WORDS));
        last_cycle = (state_q == StWait) && (cnt_q == CntW'(1));

        // Gated by rst_ni so nothing is granted while reset is held.
        data_gnt_o = rst_ni && data_req_i && ((state_q == StIdle) || last_cycle);

        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (data_gnt_o && in_range) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_we_i ? data_be_i : {BeW{1'b1}};
            mem_addr_o  = word_idx[IdxW-1:0];
            mem_wdata_o = data_wdata_i;
        end

        data_rvalid_o = last_cycle;
        data_err_o    = last_cycle && pend_err_q;
        data_rdata_o  = (last_cycle && !pend_we_q && !pend_err_q) ? mem_rdata_i : '0;
    end

    // Access sequencer: a grant (re)loads the latency counter and captures the access kind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_we_q  <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWait: begin
                    if (data_gnt_o) begin
                        state_q    <= StWait;
                        cnt_q      <= CntW'(LATENCY);
                        pend_we_q  <= data_we_i;
                        pend_err_q <= !in_range;
                    end else if (state_q == StWait) begin
                        if (last_cycle) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cnt_q      <= '0;
                    pend_we_q  <= 1'b0;
                    pend_err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coremem_ws.sv
// Directed bench for coremem_ws: three instances (LATENCY 1, 3, 4), each with
// a small SRAM model. u1 has a byte-writable RAM; u3/u4 use an address ROM.
module tb_coremem_ws;

    logic        clk;
    logic        rst_n;
    logic        rst4_n;
    logic        req1, req3, req4;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        gnt1, rv1, err1, ce1, mwe1;
    logic [31:0] rd1, mwd1, mrd1;
    logic [3:0]  mbe1;
    logic [11:0] ma1;
    logic        gnt3, rv3, err3, ce3, mwe3;
    logic [31:0] rd3, mwd3, mrd3;
    logic [3:0]  mbe3;
    logic [11:0] ma3;
    logic        gnt4, rv4, err4, ce4, mwe4;
    logic [31:0] rd4, mwd4, mrd4;
    logic [3:0]  mbe4;
    logic [11:0] ma4;

    int checks = 0;
    int passed = 0;

    coremem_ws #(.LATENCY(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1),
        .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd1), .data_err_o(err1), .mem_ce_o(ce1),
        .mem_we_o(mwe1), .mem_be_o(mbe1), .mem_addr_o(ma1), .mem_wdata_o(mwd1),
        .mem_rdata_i(mrd1)
    );

    coremem_ws #(.LATENCY(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_gnt_o(gnt3),
        .data_rvalid_o(rv3), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd3), .data_err_o(err3), .mem_ce_o(ce3),
        .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_addr_o(ma3), .mem_wdata_o(mwd3),
        .mem_rdata_i(mrd3)
    );

    coremem_ws #(.LATENCY(4)) u4 (
        .clk_i(clk), .rst_ni(rst4_n), .data_req_i(req4), .data_gnt_o(gnt4),
        .data_rvalid_o(rv4), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd4), .data_err_o(err4), .mem_ce_o(ce4),
        .mem_we_o(mwe4), .mem_be_o(mbe4), .mem_addr_o(ma4), .mem_wdata_o(mwd4),
        .mem_rdata_i(mrd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models; a cycle with no read shifts in junk so stale data is visible.
    logic [31:0] mem1 [4096];
    logic [31:0] p1;
    logic [31:0] p3 [3];
    logic [31:0] p4 [4];

    always_ff @(posedge clk) begin
        if (ce1 && mwe1) begin
            for (int b = 0; b < 4; b++) begin
                if (mbe1[b]) mem1[ma1][8*b +: 8] <= mwd1[8*b +: 8];
            end
        end
        p1 <= (ce1 && !mwe1) ? mem1[ma1] : 32'hBAD0BAD0;
    end

    always_ff @(posedge clk) begin
        p3[0] <= (ce3 && !mwe3) ? {20'hC0DE0, ma3} : 32'hBAD0BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p4[0] <= (ce4 && !mwe4) ? {20'hC0DE0, ma4} : 32'hBAD0BAD0;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    assign mrd1 = p1;
    assign mrd3 = p3[2];
    assign mrd4 = p4[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive a request on the next negedge; checks follow after #1.
    task automatic drive(input logic r1, input logic r3, input logic r4, input logic w,
                         input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req1 = r1; req3 = r3; req4 = r4; we = w; be = b; addr = a; wdata = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        req1 = 1'b0; req3 = 1'b0; req4 = 1'b0;
        we = 1'b0; be = 4'h0; addr = '0; wdata = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_rv1", {31'd0, rv1}, 32'd0);
        chk("rst_ce3", {31'd0, ce3}, 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;
        #1;
        chk("post_rst_rv1", {31'd0, rv1}, 32'd0);
        chk("post_rst_ce1", {31'd0, ce1}, 32'd0);

        // LATENCY=1 write then read
        drive(1, 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        chk("w_gnt", {31'd0, gnt1}, 32'd1);
        chk("w_ce", {31'd0, ce1}, 32'd1);
        chk("w_mwe", {31'd0, mwe1}, 32'd1);
        chk("w_maddr", {20'd0, ma1}, 32'd4);
        chk("w_rv", {31'd0, rv1}, 32'd0);
        drive(1, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        chk("r_gnt_b2b", {31'd0, gnt1}, 32'd1);
        chk("r_mbe_ones", {28'd0, mbe1}, 32'hF);
        chk("r_maddr", {20'd0, ma1}, 32'd4);
        chk("w_rv_resp", {31'd0, rv1}, 32'd1);
        chk("w_rdata0", rd1, 32'd0);
        drive(0, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        chk("r_rv", {31'd0, rv1}, 32'd1);
        chk("r_rdata", rd1, 32'hDEADBEEF);
        chk("r_err", {31'd0, err1}, 32'd0);
        chk("idle_ce", {31'd0, ce1}, 32'd0);
        drive(0, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        chk("rv_drop", {31'd0, rv1}, 32'd0);

        // Byte enables
        drive(1, 0, 0, 1, 4'hF, 32'h20, 32'h11223344);
        chk("be_w1_gnt", {31'd0, gnt1}, 32'd1);
        drive(1, 0, 0, 1, 4'b0101, 32'h20, 32'hAABBCCDD);
        chk("be_w2_gnt", {31'd0, gnt1}, 32'd1);
        chk("be_w2_mbe", {28'd0, mbe1}, 32'h5);
        drive(1, 0, 0, 0, 4'h0, 32'h20, 32'h0);
        chk("be_r_gnt", {31'd0, gnt1}, 32'd1);
        drive(0, 0, 0, 0, 4'h0, 32'h20, 32'h0);
        chk("be_rdata", rd1, 32'h11BB33DD);

        // Misaligned zero-mask write leaves word 4 unchanged
        drive(1, 0, 0, 1, 4'h0, 32'h13, 32'hFFFFFFFF);
        chk("zm_ce", {31'd0, ce1}, 32'd1);
        chk("zm_mwe", {31'd0, mwe1}, 32'd1);
        chk("zm_maddr", {20'd0, ma1}, 32'd4);
        chk("zm_mbe", {28'd0, mbe1}, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        chk("zm_rv", {31'd0, rv1}, 32'd1);
        chk("zm_err", {31'd0, err1}, 32'd0);
        drive(0, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        chk("zm_rdata", rd1, 32'hDEADBEEF);

        // Out of range: word 4096
        drive(1, 0, 0, 0, 4'h0, 32'h4000, 32'h0);
        chk("oor_gnt", {31'd0, gnt1}, 32'd1);
        chk("oor_ce", {31'd0, ce1}, 32'd0);
        chk("oor_maddr", {20'd0, ma1}, 32'd0);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk("oor_rv", {31'd0, rv1}, 32'd1);
        chk("oor_err", {31'd0, err1}, 32'd1);
        chk("oor_rdata", rd1, 32'd0);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk("oor_err_clr", {31'd0, err1}, 32'd0);

        // LATENCY=3, four back-to-back reads; the address advances after each grant
        for (int c = 0; c <= 13; c++) begin
            int k;
            logic exp_g, exp_v;
            k = (c == 0) ? 0 : (c + 2) / 3;
            exp_g = (c % 3 == 0) && (c <= 9);
            exp_v = (c % 3 == 0) && (c >= 3) && (c <= 12);
            drive(0, (c <= 9), 0, 0, 4'h0, 32'(k * 4), 32'h0);
            chk($sformatf("l3_gnt_c%0d", c), {31'd0, gnt3}, {31'd0, exp_g});
            chk($sformatf("l3_ce_c%0d", c), {31'd0, ce3}, {31'd0, exp_g});
            chk($sformatf("l3_rv_c%0d", c), {31'd0, rv3}, {31'd0, exp_v});
            if (exp_v) begin
                chk($sformatf("l3_rd_c%0d", c), rd3, {20'hC0DE0, 12'(c / 3 - 1)});
                chk($sformatf("l3_err_c%0d", c), {31'd0, err3}, 32'd0);
            end
        end

        // LATENCY=4: reset two cycles after a grant drops the response
        drive(0, 0, 1, 0, 4'h0, 32'h4, 32'h0);
        chk("l4_gnt0", {31'd0, gnt4}, 32'd1);
        drive(0, 0, 0, 0, 4'h0, 32'h4, 32'h0);
        @(negedge clk);
        rst4_n = 1'b0;
        #1;
        chk("l4_rst_rv", {31'd0, rv4}, 32'd0);
        drive(0, 0, 1, 0, 4'h0, 32'h4, 32'h0);
        chk("l4_rst_gnt", {31'd0, gnt4}, 32'd0);
        chk("l4_rst_ce", {31'd0, ce4}, 32'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        req4 = 1'b0;
        #1;
        chk("l4_rel_rv", {31'd0, rv4}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 4'h0, 32'h4, 32'h0);
            chk($sformatf("l4_norv_%0d", c), {31'd0, rv4}, 32'd0);
        end
        drive(0, 0, 1, 0, 4'h0, 32'h8, 32'h0);
        chk("l4_regnt", {31'd0, gnt4}, 32'd1);
        chk("l4_rece", {31'd0, ce4}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            drive(0, 0, 0, 0, 4'h0, 32'h8, 32'h0);
            chk($sformatf("l4_wait_rv_%0d", c), {31'd0, rv4}, 32'd0);
        end
        drive(0, 0, 0, 0, 4'h0, 32'h8, 32'h0);
        chk("l4_rv", {31'd0, rv4}, 32'd1);
        chk("l4_rdata", rd4, 32'hC0DE0002);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
